// File: rtl/sm83_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sm83_pkg
//  Description : Shared types for the SM83 control path: decoded control ops,
//                execute-step states, address-source select and ALU ops.
//  Revision    : 1.0 - initial release
// ============================================================================
package sm83_pkg;

    // Deepest step table any configuration may request; also sizes last_idx.
    localparam int c_max_depth = 16;
    localparam int c_last_w    = 4;

    typedef enum logic [3:0] {
        CTL_NOP         = 4'd0,
        CTL_LD_R8_D8    = 4'd1,
        CTL_LD_R8_R8    = 4'd2,
        CTL_ALU_R8      = 4'd3,
        CTL_LDPTR_R8_HL = 4'd4,
        CTL_LDPTR_HL_R8 = 4'd5,
        CTL_LD_R16_D16  = 4'd6,
        CTL_JR_CC       = 4'd7,
        CTL_HALT        = 4'd8
    } ctl_op_t;

    typedef enum logic [2:0] {
        EX_IDLE      = 3'd0,
        EX_MEM_TO_Z  = 3'd1,
        EX_MEM_TO_W  = 3'd2,
        EX_R8_TO_MEM = 3'd3,
        EX_ALU_LD1   = 3'd4,
        EX_ALU_R8    = 3'd5,
        EX_COND      = 3'd6,
        EX_HALT      = 3'd7
    } ctl_state_t;

    typedef enum logic [1:0] {
        ADDR_PC   = 2'd0,
        ADDR_GP16 = 2'd1,
        ADDR_SP   = 2'd2,
        ADDR_HI   = 2'd3
    } addr_sel_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_ADC  = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_SBC  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_OR   = 4'd6,
        ALU_CP   = 4'd7,
        ALU_PASS = 4'd8
    } alu_op_t;

    // Ops whose memory operand is addressed through a 16-bit register pair.
    function automatic logic is_ldptr(input ctl_op_t op);
        return (op == CTL_LDPTR_R8_HL) || (op == CTL_LDPTR_HL_R8);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ctl_seq_rom.sv
`default_nettype none
// ============================================================================
//  Module      : ctl_seq_rom
//  Description : Per-op execute step table. Returns the first SEQ_DEPTH steps
//                of the op's sequence plus the index of its final step.
//  Revision    : 1.0 - initial release
// ============================================================================
module ctl_seq_rom
    import sm83_pkg::*;
#(
    parameter int SEQ_DEPTH = 6
) (
    input  ctl_op_t                     ctl_op,
    output ctl_state_t [SEQ_DEPTH-1:0]  step_table,
    output logic [c_last_w-1:0]         last_idx
);

    // Full-depth table; entries past SEQ_DEPTH are simply not exported.
    ctl_state_t w_full [c_max_depth];

    // Decode the op into its step list; anything unlisted is a single idle step.
    always_comb begin
        for (int i = 0; i < c_max_depth; i++) begin
            w_full[i] = EX_IDLE;
        end
        last_idx = '0;
        case (ctl_op)
            CTL_LD_R8_D8, CTL_LDPTR_R8_HL: begin
                w_full[0] = EX_MEM_TO_Z;
                w_full[1] = EX_ALU_LD1;
                last_idx  = 4'd1;
            end
            CTL_LD_R8_R8: begin
                w_full[0] = EX_ALU_LD1;
                last_idx  = 4'd0;
            end
            CTL_ALU_R8: begin
                w_full[0] = EX_ALU_R8;
                last_idx  = 4'd0;
            end
            CTL_LDPTR_HL_R8: begin
                w_full[0] = EX_R8_TO_MEM;
                w_full[1] = EX_IDLE;
                last_idx  = 4'd1;
            end
            CTL_LD_R16_D16: begin
                w_full[0] = EX_MEM_TO_Z;
                w_full[1] = EX_MEM_TO_W;
                w_full[2] = EX_IDLE;
                last_idx  = 4'd2;
            end
            CTL_JR_CC: begin
                w_full[0] = EX_MEM_TO_Z;
                w_full[1] = EX_COND;
                w_full[2] = EX_IDLE;
                last_idx  = 4'd2;
            end
            CTL_HALT: begin
                w_full[0] = EX_IDLE;
                w_full[1] = EX_HALT;
                last_idx  = 4'd1;
            end
            default: begin
                last_idx = '0;
            end
        endcase
    end

    generate
        for (genvar g = 0; g < SEQ_DEPTH; g++) begin : g_table
            assign step_table[g] = w_full[g];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/ctl_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : ctl_sequencer
//  Description : Execute-step sequencer. Walks the op's step table, emits the
//                per-step datapath strobes, overlaps the next fetch with the
//                last step, and handles bus stalls and HALT/wake.
//  Revision    : 1.0 - initial release
// ============================================================================
module ctl_sequencer
    import sm83_pkg::*;
#(
    parameter int SEQ_DEPTH = 6
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  ctl_op_t                              ctl_op,
    input  alu_op_t                              decoded_alu_op,
    input  logic                                 cond_met,
    input  logic                                 mem_ready,
    input  logic                                 irq_pending,
    output alu_op_t                              alu_op,
    output addr_sel_t                            addr_sel,
    output logic [$clog2(SEQ_DEPTH)-1:0]         step_idx,
    output ctl_state_t                           step_state,
    output logic                                 inc_pc,
    output logic                                 mem_to_z,
    output logic                                 mem_to_w,
    output logic                                 mem_to_ir,
    output logic                                 mem_to_r8,
    output logic                                 capture_alu_res,
    output logic                                 r8_to_alu_op1,
    output logic                                 update_flags,
    output logic                                 r8_to_mem,
    output logic                                 fetch,
    output logic                                 halt
);

    localparam int               IDX_W     = $clog2(SEQ_DEPTH);
    localparam logic [IDX_W-1:0] c_idx_max = IDX_W'(SEQ_DEPTH - 1);

    logic [IDX_W-1:0]            r_step_idx;
    logic                        r_halt;
    ctl_state_t [SEQ_DEPTH-1:0]  w_table;
    logic [c_last_w-1:0]         w_last_idx;
    logic                        w_last_step;
    logic                        w_fetch_now;
    logic                        w_en;
    logic                        w_fetch_en;
    logic                        w_inc_pc;
    logic                        w_mem_to_z;
    logic                        w_mem_to_w;
    logic                        w_r8_to_alu_op1;
    logic                        w_capture_alu_res;
    logic                        w_update_flags;
    logic                        w_r8_to_mem;

    ctl_seq_rom #(
        .SEQ_DEPTH (SEQ_DEPTH)
    ) u_rom (
        .ctl_op     (ctl_op),
        .step_table (w_table),
        .last_idx   (w_last_idx)
    );

    assign step_state = w_table[r_step_idx];
    assign step_idx   = r_step_idx;
    assign halt       = r_halt;
    assign alu_op     = decoded_alu_op;

    // A step is last when the table says so, the table is exhausted, or a
    // branch condition failed (fetch early instead of running the tail).
    assign w_last_step = (c_last_w'(r_step_idx) >= w_last_idx)
                       || (r_step_idx == c_idx_max)
                       || ((step_state == EX_COND) && !cond_met);

    // Per-state datapath strobes and address source before stall/halt gating.
    always_comb begin
        w_inc_pc          = 1'b0;
        w_mem_to_z        = 1'b0;
        w_mem_to_w        = 1'b0;
        w_r8_to_alu_op1   = 1'b0;
        w_capture_alu_res = 1'b0;
        w_update_flags    = 1'b0;
        w_r8_to_mem       = 1'b0;
        addr_sel          = ADDR_PC;
        case (step_state)
            EX_MEM_TO_Z: begin
                w_mem_to_z = 1'b1;
                if (is_ldptr(ctl_op)) begin
                    addr_sel = ADDR_GP16;
                end else begin
                    w_inc_pc = 1'b1;
                end
            end
            EX_MEM_TO_W: begin
                w_mem_to_w = 1'b1;
                w_inc_pc   = 1'b1;
            end
            EX_R8_TO_MEM: begin
                w_r8_to_mem = 1'b1;
                addr_sel    = ADDR_GP16;
            end
            EX_ALU_LD1: begin
                w_r8_to_alu_op1   = 1'b1;
                w_capture_alu_res = 1'b1;
            end
            EX_ALU_R8: begin
                w_r8_to_alu_op1   = 1'b1;
                w_capture_alu_res = 1'b1;
                w_update_flags    = 1'b1;
            end
            default: begin
                addr_sel = ADDR_PC;
            end
        endcase
    end

    // Halted: only a wake request fetches. Running: the last step fetches,
    // except the step that puts the core to sleep.
    assign w_fetch_now = r_halt ? irq_pending
                                : (w_last_step && (step_state != EX_HALT));
    assign w_en        = mem_ready && !r_halt;
    assign w_fetch_en  = mem_ready && w_fetch_now;

    assign fetch           = w_fetch_en;
    assign mem_to_ir       = w_fetch_en;
    assign inc_pc          = (w_en && w_inc_pc) || w_fetch_en;
    assign mem_to_z        = w_en && w_mem_to_z;
    assign mem_to_w        = w_en && w_mem_to_w;
    assign mem_to_r8       = 1'b0;
    assign r8_to_alu_op1   = w_en && w_r8_to_alu_op1;
    assign capture_alu_res = w_en && w_capture_alu_res;
    assign update_flags    = w_en && w_update_flags;
    assign r8_to_mem       = w_en && w_r8_to_mem;

    // Step counter and halt flag; a stalled bus freezes both.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_step_idx <= '0;
            r_halt     <= 1'b0;
        end else if (r_halt) begin
            r_step_idx <= '0;
            if (mem_ready && irq_pending) begin
                r_halt <= 1'b0;
            end
        end else if (mem_ready) begin
            if (w_last_step) begin
                r_step_idx <= '0;
                if (step_state == EX_HALT) begin
                    r_halt <= 1'b1;
                end
            end else begin
                r_step_idx <= r_step_idx + IDX_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ctl_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ctl_sequencer
//  Description : Scoreboard bench for ctl_sequencer (default depth and a
//                depth-2 instance sharing the same stimulus).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ctl_sequencer;
    import sm83_pkg::*;

    // Strobe vector bit order:
    // [9]inc_pc [8]mem_to_z [7]mem_to_w [6]mem_to_ir [5]mem_to_r8
    // [4]capture_alu_res [3]r8_to_alu_op1 [2]update_flags [1]r8_to_mem [0]fetch
    localparam logic [9:0] c_s_inc = 10'b10_0000_0000;
    localparam logic [9:0] c_s_z   = 10'b01_0000_0000;
    localparam logic [9:0] c_s_w   = 10'b00_1000_0000;
    localparam logic [9:0] c_s_ir  = 10'b00_0100_0000;
    localparam logic [9:0] c_s_cap = 10'b00_0001_0000;
    localparam logic [9:0] c_s_op1 = 10'b00_0000_1000;
    localparam logic [9:0] c_s_flg = 10'b00_0000_0100;
    localparam logic [9:0] c_s_r2m = 10'b00_0000_0010;
    localparam logic [9:0] c_s_fet = 10'b00_0000_0001;
    localparam logic [9:0] c_none  = 10'b0;
    localparam logic [9:0] c_fetch = c_s_inc | c_s_ir | c_s_fet;
    localparam logic [9:0] c_zimm  = c_s_inc | c_s_z;
    localparam logic [9:0] c_wimm  = c_s_inc | c_s_w;
    localparam logic [9:0] c_ald   = c_s_cap | c_s_op1;

    logic     clk = 1'b0;
    logic     rst = 1'b1;
    ctl_op_t  ctl_op = CTL_LD_R16_D16;
    alu_op_t  dec_alu = ALU_ADD;
    logic     cond_met = 1'b0;
    logic     mem_ready = 1'b1;
    logic     irq_pending = 1'b0;

    always #5 clk = ~clk;

    alu_op_t    d0_alu, d1_alu;
    addr_sel_t  d0_addr, d1_addr;
    logic [2:0] d0_idx;
    logic [0:0] d1_idx;
    ctl_state_t d0_state, d1_state;
    logic d0_inc, d0_z, d0_w, d0_ir, d0_r8, d0_cap, d0_op1, d0_flg, d0_r2m, d0_fet, d0_halt;
    logic d1_inc, d1_z, d1_w, d1_ir, d1_r8, d1_cap, d1_op1, d1_flg, d1_r2m, d1_fet, d1_halt;
    logic [9:0] d0_strb, d1_strb;

    assign d0_strb = {d0_inc, d0_z, d0_w, d0_ir, d0_r8, d0_cap, d0_op1, d0_flg, d0_r2m, d0_fet};
    assign d1_strb = {d1_inc, d1_z, d1_w, d1_ir, d1_r8, d1_cap, d1_op1, d1_flg, d1_r2m, d1_fet};

    ctl_sequencer #(.SEQ_DEPTH(6)) u_dut (
        .clk(clk), .rst(rst), .ctl_op(ctl_op), .decoded_alu_op(dec_alu),
        .cond_met(cond_met), .mem_ready(mem_ready), .irq_pending(irq_pending),
        .alu_op(d0_alu), .addr_sel(d0_addr), .step_idx(d0_idx), .step_state(d0_state),
        .inc_pc(d0_inc), .mem_to_z(d0_z), .mem_to_w(d0_w), .mem_to_ir(d0_ir),
        .mem_to_r8(d0_r8), .capture_alu_res(d0_cap), .r8_to_alu_op1(d0_op1),
        .update_flags(d0_flg), .r8_to_mem(d0_r2m), .fetch(d0_fet), .halt(d0_halt)
    );

    ctl_sequencer #(.SEQ_DEPTH(2)) u_dut_d2 (
        .clk(clk), .rst(rst), .ctl_op(ctl_op), .decoded_alu_op(dec_alu),
        .cond_met(cond_met), .mem_ready(mem_ready), .irq_pending(irq_pending),
        .alu_op(d1_alu), .addr_sel(d1_addr), .step_idx(d1_idx), .step_state(d1_state),
        .inc_pc(d1_inc), .mem_to_z(d1_z), .mem_to_w(d1_w), .mem_to_ir(d1_ir),
        .mem_to_r8(d1_r8), .capture_alu_res(d1_cap), .r8_to_alu_op1(d1_op1),
        .update_flags(d1_flg), .r8_to_mem(d1_r2m), .fetch(d1_fet), .halt(d1_halt)
    );

    typedef struct {
        int         dut;
        int         idx;
        logic       halt;
        ctl_state_t state;
        logic [9:0] strb;
        addr_sel_t  addr;
        alu_op_t    alu;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Monitor: every cycle, drain the expectations queued for this cycle.
    always @(negedge clk) begin
        exp_t       e;
        int         a_idx;
        logic       a_halt;
        ctl_state_t a_state;
        logic [9:0] a_strb;
        addr_sel_t  a_addr;
        alu_op_t    a_alu;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.dut == 0) begin
                a_idx = int'(d0_idx); a_halt = d0_halt; a_state = d0_state;
                a_strb = d0_strb; a_addr = d0_addr; a_alu = d0_alu;
            end else begin
                a_idx = int'(d1_idx); a_halt = d1_halt; a_state = d1_state;
                a_strb = d1_strb; a_addr = d1_addr; a_alu = d1_alu;
            end
            n_cmp++;
            if (a_idx != e.idx || a_halt !== e.halt || a_state !== e.state ||
                a_strb !== e.strb || a_addr !== e.addr || a_alu !== e.alu) begin
                n_bad++;
                $display("FAIL %s: got idx=%0d halt=%b state=%s strb=%b addr=%0d alu=%0d, want idx=%0d halt=%b state=%s strb=%b addr=%0d alu=%0d",
                         e.name, a_idx, a_halt, a_state.name(), a_strb, a_addr, a_alu,
                         e.idx, e.halt, e.state.name(), e.strb, e.addr, e.alu);
            end
        end
    end

    // Advance one cycle and drive the inputs for it.
    task automatic cyc(input logic r, input ctl_op_t op, input logic cm,
                       input logic mr, input logic irq, input alu_op_t alu);
        @(posedge clk);
        #1;
        rst = r; ctl_op = op; cond_met = cm; mem_ready = mr;
        irq_pending = irq; dec_alu = alu;
    endtask

    // Queue the expected outputs for the current cycle.
    task automatic ex(input int dut, input int idx, input logic h, input ctl_state_t st,
                      input logic [9:0] s, input addr_sel_t a, input string nm);
        exp_t e;
        e = '{dut, idx, h, st, s, a, dec_alu, nm};
        sb.push_back(e);
    endtask

    initial begin
        // Reset state reflects entry 0 of the current op.
        cyc(1, CTL_LD_R16_D16, 0, 1, 0, ALU_ADD);
        ex(0, 0, 0, EX_MEM_TO_Z, c_zimm, ADDR_PC, "rst_state");
        ex(1, 0, 0, EX_MEM_TO_Z, c_zimm, ADDR_PC, "d2_rst_state");
        // LD_R16_D16 on both depths.
        cyc(0, CTL_LD_R16_D16, 0, 1, 0, ALU_ADD);
        ex(0, 0, 0, EX_MEM_TO_Z, c_zimm, ADDR_PC, "ld16_idx0");
        ex(1, 0, 0, EX_MEM_TO_Z, c_zimm, ADDR_PC, "d2_idx0");
        cyc(0, CTL_LD_R16_D16, 0, 1, 0, ALU_ADD);
        ex(0, 1, 0, EX_MEM_TO_W, c_wimm, ADDR_PC, "ld16_idx1");
        ex(1, 1, 0, EX_MEM_TO_W, c_wimm | c_fetch, ADDR_PC, "d2_forced_fetch");
        cyc(0, CTL_LD_R16_D16, 0, 1, 0, ALU_ADD);
        ex(0, 2, 0, EX_IDLE, c_fetch, ADDR_PC, "ld16_fetch");
        ex(1, 0, 0, EX_MEM_TO_Z, c_zimm, ADDR_PC, "d2_restart");
        // JR_CC not taken, then taken.
        cyc(0, CTL_JR_CC, 0, 1, 0, ALU_ADD);
        ex(0, 0, 0, EX_MEM_TO_Z, c_zimm, ADDR_PC, "jr_nt_idx0");
        cyc(0, CTL_JR_CC, 0, 1, 0, ALU_ADD);
        ex(0, 1, 0, EX_COND, c_fetch, ADDR_PC, "jr_nt_fetch");
        cyc(0, CTL_JR_CC, 1, 1, 0, ALU_ADD);
        ex(0, 0, 0, EX_MEM_TO_Z, c_zimm, ADDR_PC, "jr_t_idx0");
        cyc(0, CTL_JR_CC, 1, 1, 0, ALU_ADD);
        ex(0, 1, 0, EX_COND, c_none, ADDR_PC, "jr_t_cond");
        cyc(0, CTL_JR_CC, 1, 1, 0, ALU_ADD);
        ex(0, 2, 0, EX_IDLE, c_fetch, ADDR_PC, "jr_t_fetch");
        // LD_R8_D8 stalled three cycles at idx0.
        for (int i = 0; i < 3; i++) begin
            cyc(0, CTL_LD_R8_D8, 0, 0, 0, ALU_ADD);
            ex(0, 0, 0, EX_MEM_TO_Z, c_none, ADDR_PC, "stall");
        end
        cyc(0, CTL_LD_R8_D8, 0, 1, 0, ALU_ADD);
        ex(0, 0, 0, EX_MEM_TO_Z, c_zimm, ADDR_PC, "stall_release");
        cyc(0, CTL_LD_R8_D8, 0, 1, 0, ALU_ADD);
        ex(0, 1, 0, EX_ALU_LD1, c_ald | c_fetch, ADDR_PC, "ld8_alu");
        // HALT, sleep 5 cycles, wake.
        cyc(0, CTL_HALT, 0, 1, 0, ALU_ADD);
        ex(0, 0, 0, EX_IDLE, c_none, ADDR_PC, "halt_idx0");
        cyc(0, CTL_HALT, 0, 1, 0, ALU_ADD);
        ex(0, 1, 0, EX_HALT, c_none, ADDR_PC, "halt_step");
        for (int i = 0; i < 5; i++) begin
            cyc(0, CTL_HALT, 0, 1, 0, ALU_ADD);
            ex(0, 0, 1, EX_IDLE, c_none, ADDR_PC, "halted");
        end
        cyc(0, CTL_HALT, 0, 1, 1, ALU_ADD);
        ex(0, 0, 1, EX_IDLE, c_fetch, ADDR_PC, "wake");
        cyc(0, CTL_HALT, 0, 1, 0, ALU_ADD);
        ex(0, 0, 0, EX_IDLE, c_none, ADDR_PC, "awake");
        cyc(0, CTL_HALT, 0, 1, 0, ALU_ADD);
        ex(0, 1, 0, EX_HALT, c_none, ADDR_PC, "halt_again");
        cyc(0, CTL_HALT, 0, 1, 1, ALU_ADD);
        ex(0, 0, 1, EX_IDLE, c_fetch, ADDR_PC, "wake_again");
        // Asynchronous reset mid LD_R16_D16 (idx held at 1 by a stall first).
        cyc(0, CTL_LD_R16_D16, 0, 1, 0, ALU_ADD);
        ex(0, 0, 0, EX_MEM_TO_Z, c_zimm, ADDR_PC, "post_wake");
        cyc(0, CTL_LD_R16_D16, 0, 0, 0, ALU_ADD);
        ex(0, 1, 0, EX_MEM_TO_W, c_none, ADDR_PC, "ld16_hold1");
        cyc(1, CTL_LD_R16_D16, 0, 1, 0, ALU_ADD);
        ex(0, 0, 0, EX_MEM_TO_Z, c_zimm, ADDR_PC, "async_rst");
        cyc(0, CTL_LD_R16_D16, 0, 1, 0, ALU_ADD);
        ex(0, 0, 0, EX_MEM_TO_Z, c_zimm, ADDR_PC, "rst_release");
        cyc(0, CTL_LD_R16_D16, 0, 1, 0, ALU_ADD);
        ex(0, 1, 0, EX_MEM_TO_W, c_wimm, ADDR_PC, "ld16_again_idx1");
        cyc(0, CTL_LD_R16_D16, 0, 1, 0, ALU_ADD);
        ex(0, 2, 0, EX_IDLE, c_fetch, ADDR_PC, "ld16_again_fetch");
        // Pointer ops, ALU ops and an unknown op.
        cyc(0, CTL_LDPTR_HL_R8, 0, 1, 0, ALU_ADD);
        ex(0, 0, 0, EX_R8_TO_MEM, c_s_r2m, ADDR_GP16, "st_hl");
        cyc(0, CTL_LDPTR_HL_R8, 0, 1, 0, ALU_ADD);
        ex(0, 1, 0, EX_IDLE, c_fetch, ADDR_PC, "st_hl_fetch");
        cyc(0, CTL_LDPTR_R8_HL, 0, 1, 0, ALU_ADD);
        ex(0, 0, 0, EX_MEM_TO_Z, c_s_z, ADDR_GP16, "ld_hl_z");
        cyc(0, CTL_LDPTR_R8_HL, 0, 1, 0, ALU_ADD);
        ex(0, 1, 0, EX_ALU_LD1, c_ald | c_fetch, ADDR_PC, "ld_hl_alu");
        cyc(0, CTL_ALU_R8, 0, 1, 0, ALU_XOR);
        ex(0, 0, 0, EX_ALU_R8, c_ald | c_s_flg | c_fetch, ADDR_PC, "alu_r8");
        cyc(0, CTL_LD_R8_R8, 0, 1, 0, ALU_SUB);
        ex(0, 0, 0, EX_ALU_LD1, c_ald | c_fetch, ADDR_PC, "ld_r8_r8");
        cyc(0, CTL_NOP, 0, 1, 0, ALU_ADD);
        ex(0, 0, 0, EX_IDLE, c_fetch, ADDR_PC, "unknown_op");
        cyc(0, CTL_NOP, 0, 1, 0, ALU_ADD);
        ex(0, 0, 0, EX_IDLE, c_fetch, ADDR_PC, "unknown_op_repeat");

        @(posedge clk);
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
